// File: rtl/lnl_soc_pkg.sv
// Shared types and defaults for the LnL SoC keyboard input path.
// The keyboard debounce option is selected with the KBD_DEBOUNCE_EN macro
// (see kbd_input_port.sv); nothing in this package depends on it.
package lnl_soc_pkg;

    // Width of one key code as delivered on the ui_in pins.
    localparam int KBD_W = 8;

    typedef logic [KBD_W-1:0] kbd_code_t;

    // Default FIFO depth (entries) and strobe debounce length (cycles).
    localparam int KBD_DEPTH = 4;
    localparam int KBD_DBNC  = 16;

    // Occupancy counter width for a FIFO of the given depth (0..depth inclusive).
    function automatic int kbd_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Small synchronous FIFO holding key codes between the keyboard strobe
// logic and cpu0's INPR register. Head entry is visible combinationally.
//
// Handshake: push and pop are single-cycle requests with no ready/valid
// back-pressure. A pop is honoured only when the FIFO holds data (it is
// silently ignored when empty). A push is honoured when there is room or
// when a pop frees a slot on the same edge; otherwise the key is discarded
// and drop pulses for that cycle so the caller can record the overflow.
module kbd_fifo
    import lnl_soc_pkg::*;
#(
    parameter int DEPTH = KBD_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  kbd_code_t                push_data,
    input  logic                     pop,
    output kbd_code_t                head,
    output logic                     not_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = kbd_level_w(DEPTH);

    kbd_code_t             mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      level_nxt;
    logic                  not_empty_q;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    // Decide which requests actually take effect this cycle.
    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        do_pop  = pop & not_empty_q;
        do_push = push & (~full | do_pop);
        drop    = push & full & ~do_pop;
    end

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_nxt = level_q;
        case ({do_push, do_pop})
            2'b10:   level_nxt = level_q + LVL_W'(1);
            2'b01:   level_nxt = level_q - LVL_W'(1);
            default: level_nxt = level_q;
        endcase
    end

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            not_empty_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level_q     <= level_nxt;
            not_empty_q <= (level_nxt != '0);
        end
    end

    // Head entry is forced to zero while the FIFO is empty.
    always_comb begin
        head = not_empty_q ? mem[rd_ptr] : '0;
    end

    assign not_empty = not_empty_q;
    assign level     = level_q;

endmodule

// File: rtl/kbd_input_port.sv
// Keyboard input stage feeding cpu0's INPR/FGI path.
// Synchronises the asynchronous key strobe, detects its rising edge,
// captures the key code into kbd_fifo and exposes the head as INPR with
// FGI = "FIFO not empty". Each INP (fgi_clr pulse) consumes one entry.
//
// Build option KBD_DEBOUNCE_EN: when defined, the synchronised strobe is
// filtered so it must hold a new level for DBNC_CYCLES consecutive cycles
// before it is accepted; push latency grows by DBNC_CYCLES edges.
module kbd_input_port
    import lnl_soc_pkg::*;
#(
    parameter int DEPTH       = KBD_DEPTH,
    parameter int DBNC_CYCLES = KBD_DBNC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  kbd_code_t               kbd_data,
    input  logic                    kbd_stb,
    input  logic                    fgi_clr,
    input  logic                    ovf_clr,
    output kbd_code_t               inpr,
    output logic                    fgi,
    output logic                    ovf,
    output logic [$clog2(DEPTH):0]  level
);

    // Reject configurations the FIFO pointer arithmetic cannot support.
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || DBNC_CYCLES < 1) begin : g_bad_params
        $error("kbd_input_port: DEPTH must be a power of two in 2..16 and DBNC_CYCLES >= 1");
    end

    logic stb_s1;
    logic stb_s2;
    logic stb_f;
    logic stb_d;
    logic push;
    logic pop;
    logic drop;
    logic fifo_ne;

    // Two-flop synchroniser for the asynchronous strobe pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            stb_s1 <= 1'b0;
            stb_s2 <= 1'b0;
        end else begin
            stb_s1 <= kbd_stb;
            stb_s2 <= stb_s1;
        end
    end

`ifdef KBD_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DBNC_CYCLES + 1);

    logic [CNT_W-1:0] dbnc_cnt;

    // Accept a new strobe level only after it has persisted DBNC_CYCLES cycles;
    // any return to the filtered level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbnc_cnt <= '0;
            stb_f    <= 1'b0;
        end else if (stb_s2 != stb_f) begin
            if (dbnc_cnt == CNT_W'(DBNC_CYCLES - 1)) begin
                stb_f    <= stb_s2;
                dbnc_cnt <= '0;
            end else begin
                dbnc_cnt <= dbnc_cnt + CNT_W'(1);
            end
        end else begin
            dbnc_cnt <= '0;
        end
    end
`else
    assign stb_f = stb_s2;
`endif

    // Delayed copy of the (filtered) strobe for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            stb_d <= 1'b0;
        end else begin
            stb_d <= stb_f;
        end
    end

    assign push = stb_f & ~stb_d;
    assign pop  = fgi_clr & fgi_fifo_ne();

    // Small helper keeps the pop qualification readable next to push.
    function automatic logic fgi_fifo_ne();
        return fifo_ne;
    endfunction

    kbd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (kbd_data),
        .pop       (pop),
        .head      (inpr),
        .not_empty (fifo_ne),
        .level     (level),
        .drop      (drop)
    );

    assign fgi = fifo_ne;

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kbd_input_port.sv
// Bench for kbd_input_port: directed scenarios plus randomized key/pop
// traffic, all outputs compared every cycle against a queue-based model.
module tb_kbd_input_port;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef KBD_DEBOUNCE_EN
    localparam int DBNC  = 16;
    localparam int LAT   = 3 + DBNC;
    localparam int HOLD  = 20;
    localparam int GAP   = 20;
`else
    localparam int DBNC  = 0;
    localparam int LAT   = 3;
    localparam int HOLD  = 4;
    localparam int GAP   = 3;
`endif

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       kbd_data = '0;
    logic             kbd_stb = 1'b0;
    logic             fgi_clr = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [7:0]       inpr;
    logic             fgi;
    logic             ovf;
    logic [LVL_W-1:0] level;

    always #5 clk = ~clk;

    kbd_input_port #(
        .DEPTH       (DEPTH),
        .DBNC_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .kbd_data (kbd_data),
        .kbd_stb  (kbd_stb),
        .fgi_clr  (fgi_clr),
        .ovf_clr  (ovf_clr),
        .inpr     (inpr),
        .fgi      (fgi),
        .ovf      (ovf),
        .level    (level)
    );

    // ---------------- scoreboard / model ----------------
    logic [7:0] exp_q[$];
    int         pend_edge[$];
    logic [7:0] pend_data[$];
    logic       exp_ovf = 1'b0;
    int         edge_cnt = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
    endtask

    // Apply the effect of one clock edge to the model, using the inputs held across it.
    task automatic model_edge();
        logic       pop_ok;
        logic       do_push;
        logic       dropped;
        logic [7:0] d;
        if (rst) begin
            exp_q.delete();
            pend_edge.delete();
            pend_data.delete();
            exp_ovf = 1'b0;
            return;
        end
        pop_ok  = fgi_clr && (exp_q.size() > 0);
        do_push = (pend_edge.size() > 0) && (pend_edge[0] == edge_cnt);
        dropped = 1'b0;
        d       = '0;
        if (do_push) begin
            d = pend_data.pop_front();
            void'(pend_edge.pop_front());
        end
        if (pop_ok) void'(exp_q.pop_front());
        if (do_push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else dropped = 1'b1;
        end
        if (dropped) exp_ovf = 1'b1;
        else if (ovf_clr) exp_ovf = 1'b0;
    endtask

    // One clock: update model at the edge, compare all outputs at the falling edge.
    task automatic step();
        @(posedge clk);
        edge_cnt++;
        model_edge();
        @(negedge clk);
        check("inpr",  {24'b0, inpr}, (exp_q.size() > 0) ? {24'b0, exp_q[0]} : 32'h0);
        check("fgi",   {31'b0, fgi}, {31'b0, (exp_q.size() > 0)});
        check("ovf",   {31'b0, ovf}, {31'b0, exp_ovf});
        check("level", {29'b0, level}, exp_q.size());
    endtask

    // ---------------- driver tasks ----------------
    // Change the strobe pin; a rise held long enough is expected to land LAT edges later.
    task automatic set_stb(input logic v, input int hold);
        if (v && !kbd_stb && hold > DBNC) begin
            pend_edge.push_back(edge_cnt + LAT);
            pend_data.push_back(kbd_data);
        end
        kbd_stb = v;
    endtask

    task automatic run(input int n, input int pop_pct, input int ovf_pct);
        for (int i = 0; i < n; i++) begin
            fgi_clr = ($urandom_range(0, 99) < pop_pct);
            ovf_clr = ($urandom_range(0, 99) < ovf_pct);
            step();
        end
        fgi_clr = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic key(input logic [7:0] d, input int pop_pct, input int ovf_pct);
        kbd_data = d;
        set_stb(1'b1, HOLD);
        run(HOLD, pop_pct, ovf_pct);
        set_stb(1'b0, 0);
        run(GAP, pop_pct, ovf_pct);
    endtask

    // Key whose write edge coincides with an fgi_clr and/or ovf_clr pulse.
    task automatic key_with(input logic [7:0] d, input logic p, input logic oc);
        kbd_data = d;
        set_stb(1'b1, HOLD);
        run(LAT - 1, 0, 0);
        fgi_clr = p;
        ovf_clr = oc;
        step();
        fgi_clr = 1'b0;
        ovf_clr = 1'b0;
        run(HOLD - LAT, 0, 0);
        set_stb(1'b0, 0);
        run(GAP, 0, 0);
    endtask

    task automatic pop_one();
        fgi_clr = 1'b1;
        step();
        fgi_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_stb(1'b0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        check("rst_level", {29'b0, level}, 0);
        check("rst_fgi", {31'b0, fgi}, 0);

        // First key: inpr/fgi/level appear exactly LAT edges after the pin rises.
        kbd_data = 8'h41;
        set_stb(1'b1, HOLD);
        run(LAT - 1, 0, 0);
        check("t1_early_fgi", {31'b0, fgi}, 0);
        step();
        check("t1_inpr", {24'b0, inpr}, 32'h41);
        check("t1_level", {29'b0, level}, 1);
        run(HOLD - LAT, 0, 0);
        set_stb(1'b0, 0);
        run(GAP, 0, 0);
        pop_one();

        // Four keys, then in-order drain.
        for (int i = 0; i < 4; i++) key(8'h61 + 8'(i), 0, 0);
        check("t2_level", {29'b0, level}, 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_order", {24'b0, inpr}, 32'h61 + i);
            pop_one();
        end
        check("t2_fgi", {31'b0, fgi}, 0);

        // Fifth key into a full FIFO is dropped; ovf sticks until cleared.
        for (int i = 0; i < 5; i++) key(8'h61 + 8'(i), 0, 0);
        check("t3_ovf", {31'b0, ovf}, 1);
        check("t3_level", {29'b0, level}, 4);
        check("t3_head", {24'b0, inpr}, 32'h61);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", {31'b0, ovf}, 0);

        // Full FIFO: push with a simultaneous pop keeps level and does not overflow.
        key_with(8'h65, 1'b1, 1'b0);
        check("t4_level", {29'b0, level}, 4);
        check("t4_ovf", {31'b0, ovf}, 0);
        for (int i = 0; i < 4; i++) begin
            check("t4_order", {24'b0, inpr}, 32'h62 + i);
            pop_one();
        end

        // Overflow drop with ovf_clr on the same edge: set wins.
        for (int i = 0; i < 4; i++) key(8'h30 + 8'(i), 0, 0);
        key_with(8'h39, 1'b0, 1'b1);
        check("t4_set_wins", {31'b0, ovf}, 1);
        do_reset();

        // Pop while empty is ignored; reset mid-strobe discards the key.
        pop_one();
        check("t5_empty_level", {29'b0, level}, 0);
        kbd_data = 8'h55;
        set_stb(1'b1, HOLD);
        step();
        do_reset();
        run(LAT + 6, 0, 0);
        check("t5_no_push", {29'b0, level}, 0);

`ifdef KBD_DEBOUNCE_EN
        // Short glitch is filtered; a long strobe gives exactly one key.
        kbd_data = 8'h77;
        set_stb(1'b1, 10);
        run(10, 0, 0);
        set_stb(1'b0, 0);
        run(GAP + 10, 0, 0);
        check("t6_glitch", {29'b0, level}, 0);
        key(8'h78, 0, 0);
        check("t6_one_push", {29'b0, level}, 1);
        pop_one();
`endif

        // Randomized traffic in phases of varying pop pressure.
        for (int ph = 0; ph < 6; ph++) begin
            int pop_pct;
            pop_pct = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 30 : 70);
            for (int k = 0; k < 12; k++) begin
                key(8'($urandom_range(0, 255)), pop_pct, 8);
            end
        end
        run(20, 50, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
